// File: rtl/disp_pkg.sv
// disp_pkg: mode encodings and display geometry shared by the display controller.
package disp_pkg;
  localparam int DIGITS = 8;
  localparam int DCTR_W = 5;
  typedef enum logic [2:0] {
    EDIT_A   = 3'b000,
    EDIT_B   = 3'b001,
    SHOW_RES = 3'b010,
    SHOW_AB  = 3'b011
  } mode_e;
endpackage

// File: rtl/disp_mode_ctrl_if.sv
// disp_mode_ctrl_if: operand/result inputs and multiplexed display outputs of the controller.
interface disp_mode_ctrl_if;
  logic [31:0]                    ai;
  logic [31:0]                    bi;
  logic [31:0]                    res;
  logic [disp_pkg::DIGITS-1:0]    blink;
  logic [disp_pkg::DCTR_W-1:0]    dctr;
  logic [disp_pkg::DIGITS-1:0]    an;
  logic [3:0]                     hex;
  logic                           dp;
  modport master (input ai, bi, res, blink, output dctr, an, hex, dp);
  modport slave  (output ai, bi, res, blink, input dctr, an, hex, dp);
endinterface

// File: rtl/disp_mode_ctrl_btn_edge.sv
// btn_edge: two-flop synchroniser plus previous-value flop giving a one-cycle rising-edge pulse.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic edge_o
);
  logic [2:0] sh_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sh_q <= '0;
    else sh_q <= {sh_q[1:0], btn_i};
  // sh_q[1] is the synchronised level, sh_q[2] its previous value
  assign edge_o = sh_q[1] & ~sh_q[2];
endmodule

// File: rtl/disp_mode_ctrl.sv
// disp_mode_ctrl: mode/op FSM and 8-digit seven-segment scan scheduler.
// Define LEAD_ZERO_BLANK_EN to blank leading-zero digits in the SHOW modes.
module disp_mode_ctrl
  import disp_pkg::*;
#(
  parameter int SCAN_DIV  = 16,
  parameter int BLINK_DIV = 64,
  parameter int ALT_PH    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_mode_i,
  input  logic              btn_op_i,
  input  logic              hold_i,
  disp_mode_ctrl_if.master  bus
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam int AW = $clog2(ALT_PH + 1);
  mode_e              mode_q, mode_d;
  logic [1:0]         op_q, op_d;
  logic [DCTR_W-1:0]  dctr_q;
  logic [CW-1:0]      cnt_q;
  logic [BW-1:0]      bcnt_q;
  logic [AW-1:0]      acnt_q;
  logic [2:0]         idx_q;
  logic               ph_q, alt_b_q;
  logic [3:0]         hex_q, hex_d;
  logic [DIGITS-1:0]  an_q, an_d;
  logic               dp_q, dp_d;
  logic               mode_ev, op_ev, mode_up, op_up, mode_chg, tick, ptog, atog, blank;
  logic [31:0]        src;
  btn_edge u_mode (.clk(clk), .rst_n(rst_n), .btn_i(btn_mode_i), .edge_o(mode_ev));
  btn_edge u_op   (.clk(clk), .rst_n(rst_n), .btn_i(btn_op_i),   .edge_o(op_ev));
  assign mode_up  = mode_ev & ~hold_i;
  assign op_up    = op_ev & ~hold_i & ~mode_ev & (mode_q == SHOW_RES);
  assign mode_chg = mode_d != mode_q;
  assign tick     = cnt_q == CW'(SCAN_DIV - 1);
  assign ptog     = tick & (bcnt_q == BW'(BLINK_DIV - 1));
  assign atog     = ptog & (acnt_q == AW'(ALT_PH - 1));
  always_comb begin
    mode_d = mode_q;
    op_d   = op_q;
    if (mode_q[2]) mode_d = EDIT_A;
    else if (mode_up) mode_d = mode_e'({1'b0, mode_q[1:0] + 2'd1});
    else if (op_up) op_d = op_q + 2'd1;
  end
  always_comb begin
    src   = (mode_q == EDIT_B) ? bus.bi :
            (mode_q == SHOW_RES) ? bus.res :
            (mode_q == SHOW_AB && alt_b_q) ? bus.bi : bus.ai;
    hex_d = src[{idx_q, 2'b00} +: 4];
    blank = (mode_q == EDIT_A || mode_q == EDIT_B) && ph_q && bus.blink[idx_q];
`ifdef LEAD_ZERO_BLANK_EN
    blank = blank | ((mode_q == SHOW_RES || mode_q == SHOW_AB) && idx_q != 3'd0 &&
                     (src >> {idx_q, 2'b00}) == 32'd0);
`endif
    an_d  = blank ? '1 : ~(DIGITS'(1) << idx_q);
    dp_d  = idx_q == 3'd7 && mode_q == SHOW_AB && alt_b_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mode_q  <= EDIT_A;
      op_q    <= '0;
      dctr_q  <= '0;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      acnt_q  <= '0;
      idx_q   <= '0;
      ph_q    <= 1'b0;
      alt_b_q <= 1'b0;
      hex_q   <= '0;
      an_q    <= '1;
      dp_q    <= 1'b0;
    end else begin
      mode_q <= mode_d;
      op_q   <= op_d;
      dctr_q <= {mode_q, op_q};
      cnt_q  <= tick ? '0 : cnt_q + CW'(1);
      if (tick) idx_q <= idx_q + 3'd1;
      if (tick) bcnt_q <= ptog ? '0 : bcnt_q + BW'(1);
      if (ptog) ph_q <= ~ph_q;
      if (mode_chg || mode_q != SHOW_AB) begin
        acnt_q  <= '0;
        alt_b_q <= 1'b0;
      end else if (ptog) begin
        acnt_q  <= atog ? '0 : acnt_q + AW'(1);
        alt_b_q <= alt_b_q ^ atog;
      end
      hex_q <= hex_d;
      an_q  <= an_d;
      dp_q  <= dp_d;
    end
  assign bus.dctr = dctr_q;
  assign bus.an   = an_q;
  assign bus.hex  = hex_q;
  assign bus.dp   = dp_q;
endmodule

// File: tb/tb_disp_mode_ctrl.sv
// tb_disp_mode_ctrl: randomized buttons/data against a cycle-count based reference model.
module tb_disp_mode_ctrl;
  localparam int SD = 4, BD = 2, AP = 1;
  logic clk = 1'b0, rst_n = 1'b0, btn_mode = 1'b0, btn_op = 1'b0, hold = 1'b0;
  int n_tests = 0, n_fail = 0;
  disp_mode_ctrl_if bus();
  disp_mode_ctrl #(.SCAN_DIV(SD), .BLINK_DIV(BD), .ALT_PH(AP)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode_i(btn_mode), .btn_op_i(btn_op),
    .hold_i(hold), .bus(bus.master)
  );
  always #5 clk = ~clk;
  // reference model: scan position from edges since reset, buttons as a delay line
  int n, tog, idx, ph;
  logic [1:0] m_mode, m_op;
  logic m_altb, mev, oev, ptog, blank;
  logic [2:0] hm, ho;
  logic [31:0] src;
  logic [4:0] e_dctr;
  logic [7:0] e_an;
  logic [3:0] e_hex;
  logic e_dp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0; tog = 0; m_mode = 0; m_op = 0; m_altb = 0; hm = 0; ho = 0;
      e_dctr = 0; e_an = 8'hFF; e_hex = 0; e_dp = 0;
    end else begin
      idx = (n / SD) % 8;
      ph  = (n / (SD * BD)) % 2;
      src = m_mode == 2'd1 ? bus.bi : m_mode == 2'd2 ? bus.res :
            (m_mode == 2'd3 && m_altb) ? bus.bi : bus.ai;
      e_hex = src[4*idx +: 4];
      blank = m_mode < 2'd2 && ph == 1 && bus.blink[idx];
`ifdef LEAD_ZERO_BLANK_EN
      if (m_mode >= 2'd2 && idx > 0 && (src >> (4 * idx)) == 32'd0) blank = 1'b1;
`endif
      e_an   = blank ? 8'hFF : ~(8'h01 << idx);
      e_dp   = idx == 7 && m_mode == 2'd3 && m_altb;
      e_dctr = {1'b0, m_mode, m_op};
      mev = hm[1] & ~hm[2];
      oev = ho[1] & ~ho[2];
      hm = {hm[1:0], btn_mode};
      ho = {ho[1:0], btn_op};
      ptog = (n + 1) % (SD * BD) == 0;
      if (!hold && mev) begin
        m_mode = m_mode + 2'd1; tog = 0; m_altb = 1'b0;
      end else begin
        if (!hold && oev && m_mode == 2'd2) m_op = m_op + 2'd1;
        if (m_mode == 2'd3 && ptog) begin
          tog++;
          m_altb = ((tog / AP) % 2) == 1;
        end
      end
      n++;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    chk("dctr", 32'(bus.dctr), 32'(e_dctr));
    chk("an",   32'(bus.an),   32'(e_an));
    chk("hex",  32'(bus.hex),  32'(e_hex));
    chk("dp",   32'(bus.dp),   32'(e_dp));
  endtask
  task automatic check_reset();
    chk("rst_dctr", 32'(bus.dctr), 32'd0);
    chk("rst_an",   32'(bus.an),   32'hFF);
    chk("rst_hex",  32'(bus.hex),  32'd0);
    chk("rst_dp",   32'(bus.dp),   32'd0);
  endtask
  function automatic logic [31:0] rnd();
    return $urandom_range(0, 3) == 0 ? 32'd0 : ($urandom >> $urandom_range(0, 31));
  endfunction
  int len, pm, po, phd;
  initial begin
    bus.ai = 32'h87654321; bus.bi = 32'h12345678; bus.res = 32'h000000A3; bus.blink = 8'h04;
    repeat (3) @(negedge clk);
    check_reset();
    rst_n = 1'b1;
    for (int s = 0; s < 60; s++) begin
      len = $urandom_range(20, 150);
      pm  = s % 3 == 0 ? 0 : $urandom_range(0, 1) ? 3 : 15;
      po  = $urandom_range(0, 2) * 15;
      phd = s % 4 == 0 ? 50 : 5;
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        check_all();
        btn_mode = $urandom_range(0, 99) < pm;
        btn_op   = $urandom_range(0, 99) < po;
        hold     = $urandom_range(0, 99) < phd;
        if ($urandom_range(0, 9) == 0) bus.ai = rnd();
        if ($urandom_range(0, 9) == 0) bus.bi = rnd();
        if ($urandom_range(0, 9) == 0) bus.res = rnd();
        if ($urandom_range(0, 19) == 0) bus.blink = 8'($urandom);
      end
      if (s == 30) begin
        rst_n = 1'b0;
        @(negedge clk);
        check_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/disp_mode_ctrl.md
Name: disp_mode_ctrl

Overview:
Mode controller and 8-digit seven-segment scan scheduler for the operand-entry/display path.
- Generates the 5-bit Dctr mode word that gates operand editing: bits [4:2] = mode, bits [1:0] = op select.
- Shares one multiplexed hex display between operand A, operand B and the result.
- Time-multiplexes the digit enables and applies the per-digit blink mask from the operand editor.

Parameters:
SCAN_DIV, 16, clk cycles per digit-scan tick (≥2)
BLINK_DIV, 64, scan ticks per blink-phase toggle (≥1)
ALT_PH, 4, blink-phase toggles per A/B alternation in SHOW_AB (≥1)

Ports:
clk  in  1  system clock; all state on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
btn_mode  in  1  raw mode button, asynchronous to clk
btn_op  in  1  raw op-select button, asynchronous to clk
hold  in  1  level; when 1, mode and op are frozen
ai  in  32  operand A
bi  in  32  operand B
res  in  32  result word
blink  in  8  per-digit blink request, bit i = digit i
dctr  out  5  {mode[2:0], op[1:0]}
an  out  8  digit enables, active-low, one-hot-low or all-ones
hex  out  4  nibble for the enabled digit
dp  out  1  decimal point, active-high

Behaviour:
- Reset: rst_n low asynchronously clears every register.
  - Outputs: mode=EDIT_A, op=0, dctr=5'b00000, an=8'hFF, hex=0, dp=0.
  - Internal: scan counter=0, digit index=0, blink phase=0, alt counter=0, alt source=A, synchronisers=0.
  - Mid-operation reset aborts scanning immediately; there is no partial state.
- Button inputs:
  - Each button passes through a 2-flop synchroniser plus a previous-value flop.
  - edge = sync & ~prev.
  - A raw button first sampled high at edge k causes the register update at edge k+2.
- Mode FSM (3-bit state), advances on a mode edge when hold=0:
  - EDIT_A(000) -> EDIT_B(001) -> SHOW_RES(010) -> SHOW_AB(011) -> EDIT_A.
  - Codes 100-111 are unreachable; if entered, the FSM returns to EDIT_A on the next clk.
- op: 2-bit, increments on an op edge only in SHOW_RES with hold=0; wraps 3->0.
- Simultaneous mode and op edges: mode wins and the op edge is discarded.
- Any mode change clears the alt counter and sets alt source=A.
- dctr is registered and equals {mode, op} one cycle after the state update.
- Scan:
  - The counter counts 0..SCAN_DIV-1; scan tick = (count==SCAN_DIV-1).
  - On tick, digit index increments and wraps 7->0.
  - On every BLINK_DIV-th tick, blink phase toggles.
- Alternation: in SHOW_AB, each phase toggle increments the alt counter. At ALT_PH toggles the counter clears and alt source flips A<->B. Outside SHOW_AB, alt source is held at A.
- Source select:
  - EDIT_A -> ai
  - EDIT_B -> bi
  - SHOW_RES -> res
  - SHOW_AB -> ai or bi per alt source
- Registered outputs (1-cycle latency from index/phase/source):
  - hex = src[4*idx+3 : 4*idx].
  - an = ~(8'b1<<idx), but an=8'hFF when blink[idx]=1, phase=1 and mode is EDIT_A/EDIT_B.
  - blink is ignored in the SHOW modes.
  - dp = 1 only when idx=7, mode=SHOW_AB and source=B.
- Inputs ai/bi/res/blink are sampled every cycle; there is no capture latch.

Optional Feature:
- LEAD_ZERO_BLANK_EN defined:
  - In SHOW_RES/SHOW_AB, a digit whose nibble and all higher nibbles of the source are zero drives an=8'hFF.
  - Digit 0 is never blanked.
- Undefined: all digits are displayed, including leading zeros.

Decomposition:
- Package disp_pkg:
  - mode encodings EDIT_A/EDIT_B/SHOW_RES/SHOW_AB (3-bit localparams)
  - DIGITS=8
  - DCTR_W=5
- Sub-module btn_edge (sync + edge detect), instantiated twice.
- The FSM, scan and mux stay in disp_mode_ctrl.

Test Plan:
1. Reset check, with SCAN_DIV=4, BLINK_DIV=2: hold rst_n=0 -> dctr=0, an=FF, hex=0, dp=0. Release rst_n -> an cycles FE,FD,...,7F,FE with each digit held 4 clks.
2. Mode cycling: ai=87654321, one btn_mode pulse per mode -> dctr 00,04,08,0C,00. Each update occurs 2 edges after first sample. With hold=1, pulses leave dctr unchanged.
3. Op select: in SHOW_RES, 5 btn_op pulses -> dctr 08,09,0A,0B,08,09. A same-cycle btn_mode+btn_op pulse -> dctr=0C, op unchanged.
4. Blink: EDIT_A, blink=8'h04 -> at idx=2, an=FB when phase=0 and FF when phase=1. In SHOW_RES, an=FB in both phases.
5. Alternation: SHOW_AB, ai=87654321, bi=12345678, ALT_PH=1 -> digit 0 hex toggles 1/8 each phase toggle. dp=1 at idx=7 only while showing B.
6. Optional feature: with LEAD_ZERO_BLANK_EN and res=0000_00A3 in SHOW_RES -> digits 7..2 an=FF, digits 1,0 shown (A,3). With res=0, digit 0 is shown as 0.
